tdm_demux_4ch: RTL

//  - Receive end of the 4-lane time-division link. The transmit side scans a 4:1 mux with a 2-bit select.
//  - This block re-derives that select from a frame sync and steers each slot into its lane register.
//  - It presents one 4-lane frame in parallel, with a valid pulse.
//  - Sits between the serial link pins and the lane consumers.

---
 rtl/tdm_demux_4ch_pkg.sv | 29 ++
 rtl/tdm_demux_4ch_if.sv | 39 +++
 rtl/tdm_demux_4ch_slot_counter.sv | 37 +++
 rtl/tdm_demux_4ch.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/tdm_demux_4ch_pkg.sv
// Shared definitions for the 4-lane TDM link (receive demux and transmit scanner).
// Holds the lane/select geometry, the FSM state encoding, the loss-watchdog
// limit and the one-hot lane decode used for shadow register steering.
package tdm_demux_4ch_pkg;

    localparam int NUM_LANES  = 4;
    localparam int SEL_W      = 2;
    localparam int LOSS_LIMIT = 4;
    localparam int ERR_CNT_W  = 2;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_LOCK = 1'b1
    } tdm_state_e;

    // One-hot decode of a slot index into per-lane write enables.
    function automatic logic [NUM_LANES-1:0] lane_decode(input logic [SEL_W-1:0] idx);
        logic [NUM_LANES-1:0] onehot;
        case (idx)
            2'd0:    onehot = 4'b0001;
            2'd1:    onehot = 4'b0010;
            2'd2:    onehot = 4'b0100;
            2'd3:    onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/tdm_demux_4ch_if.sv
// Link-side bus of the TDM demux: serial slot input plus the parallel frame
// outputs. The master modport is the link/consumer side, slave is the demux.
interface tdm_demux_4ch_if #(
    parameter int W = 8
) ();
    import tdm_demux_4ch_pkg::*;

    logic [W-1:0]           din;
    logic                   din_valid;
    logic                   sync;
    logic [SEL_W-1:0]       sel;
    logic [NUM_LANES*W-1:0] lanes;
    logic                   frame_vld;
    logic                   locked;
    logic                   sync_err;

    modport master (
        output din,
        output din_valid,
        output sync,
        input  sel,
        input  lanes,
        input  frame_vld,
        input  locked,
        input  sync_err
    );

    modport slave (
        input  din,
        input  din_valid,
        input  sync,
        output sel,
        output lanes,
        output frame_vld,
        output locked,
        output sync_err
    );

endinterface

// File: rtl/tdm_demux_4ch_slot_counter.sv
// tdm_slot_counter: 2-bit wrapping slot counter of the TDM receiver.
// clr (highest priority) returns to slot 0, load forces slot 1 (a sync was
// taken as slot 0 this cycle), en advances with wrap 3->0. wrap flags the
// cycle in which slot 3 is consumed.
module tdm_slot_counter
    import tdm_demux_4ch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic             clr,
    output logic [SEL_W-1:0] slot,
    output logic             wrap
);

    logic [SEL_W-1:0] slot_r;

    // Slot index register: clear, load-to-1 on sync, else advance when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_r <= 2'd0;
        end else if (clr) begin
            slot_r <= 2'd0;
        end else if (load) begin
            slot_r <= 2'd1;
        end else if (en) begin
            slot_r <= slot_r + 2'd1;
        end else begin
            slot_r <= slot_r;
        end
    end

    assign slot = slot_r;
    assign wrap = en & (slot_r == 2'd3);

endmodule

// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: receive end of the 4-lane time-division link.
// Re-derives the transmit mux select from the frame sync, steers each slot
// into a shadow lane register and publishes a complete 4-lane frame with a
// one-cycle frame_vld pulse. A sync seen away from slot 0 while locked
// realigns immediately and raises a one-cycle sync_err.
// Optional build macro TDM_DEMUX_LOSS_EN: after 4 consecutive sync errors
// (no clean frame in between) the block drops lock and returns to HUNT.
module tdm_demux_4ch
    import tdm_demux_4ch_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    tdm_demux_4ch_if.slave   bus
);

    tdm_state_e             state_r;
    logic [W-1:0]           shadow_r [0:NUM_LANES-2];
    logic [NUM_LANES*W-1:0] lanes_r;
    logic                   frame_vld_r;
    logic                   sync_err_r;

    logic [SEL_W-1:0]       slot_s;
    logic                   wrap_s;
    logic                   sync_take_s;
    logic                   in_lock_s;
    logic                   cnt_en_s;
    logic [SEL_W-1:0]       sel_s;
    logic [NUM_LANES-1:0]   lane_we_s;
    logic                   misalign_s;
    logic                   frame_done_s;
    logic                   loss_s;

    tdm_slot_counter u_slot_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en_s),
        .load  (sync_take_s),
        .clr   (loss_s),
        .slot  (slot_s),
        .wrap  (wrap_s)
    );

    // Slot steering: sync forces slot 0, otherwise the counter selects the lane.
    always_comb begin
        sync_take_s = bus.din_valid & bus.sync;
        in_lock_s   = (state_r == ST_LOCK);
        cnt_en_s    = bus.din_valid & in_lock_s;
        if (sync_take_s) begin
            sel_s = 2'd0;
        end else begin
            sel_s = slot_s;
        end
        if (sync_take_s | cnt_en_s) begin
            lane_we_s = lane_decode(sel_s);
        end else begin
            lane_we_s = 4'b0000;
        end
        misalign_s   = in_lock_s & sync_take_s & (slot_s != 2'd0);
        frame_done_s = wrap_s & lane_we_s[NUM_LANES-1];
    end

`ifdef TDM_DEMUX_LOSS_EN
    localparam logic [ERR_CNT_W-1:0] ERR_LAST = ERR_CNT_W'(LOSS_LIMIT - 1);

    logic [ERR_CNT_W-1:0] err_cnt_r;

    // Loss of lock fires on the error that reaches the consecutive-error limit.
    always_comb begin
        if (misalign_s && (err_cnt_r == ERR_LAST)) begin
            loss_s = 1'b1;
        end else begin
            loss_s = 1'b0;
        end
    end

    // Consecutive sync-error counter; any clean full frame clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= 2'd0;
        end else if (loss_s || frame_done_s) begin
            err_cnt_r <= 2'd0;
        end else if (misalign_s) begin
            err_cnt_r <= err_cnt_r + 2'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end
`else
    assign loss_s = 1'b0;
`endif

    // Lock FSM, shadow lane capture, frame publication and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_HUNT;
            lanes_r     <= '0;
            frame_vld_r <= 1'b0;
            sync_err_r  <= 1'b0;
            for (int k = 0; k < NUM_LANES - 1; k++) begin
                shadow_r[k] <= '0;
            end
        end else begin
            frame_vld_r <= frame_done_s;
            sync_err_r  <= misalign_s;

            for (int k = 0; k < NUM_LANES - 1; k++) begin
                if (lane_we_s[k]) begin
                    shadow_r[k] <= bus.din;
                end else begin
                    shadow_r[k] <= shadow_r[k];
                end
            end

            if (frame_done_s) begin
                lanes_r <= {bus.din, shadow_r[2], shadow_r[1], shadow_r[0]};
            end else begin
                lanes_r <= lanes_r;
            end

            case (state_r)
                ST_HUNT: begin
                    if (sync_take_s) begin
                        state_r <= ST_LOCK;
                    end else begin
                        state_r <= ST_HUNT;
                    end
                end
                ST_LOCK: begin
                    if (loss_s) begin
                        state_r <= ST_HUNT;
                    end else begin
                        state_r <= ST_LOCK;
                    end
                end
                default: begin
                    state_r <= ST_HUNT;
                end
            endcase
        end
    end

    assign bus.sel       = sel_s;
    assign bus.lanes     = lanes_r;
    assign bus.frame_vld = frame_vld_r;
    assign bus.locked    = (state_r == ST_LOCK);
    assign bus.sync_err  = sync_err_r;

endmodule
